soc_mem_rmw: RTL and testbench

//  Bus adapter between the CPU data port and soc_bram_ctl. Turns byte/half/word loads and

---
 rtl/soc_mem_rmw_if.sv | 32 +++
 rtl/soc_mem_rmw.sv | 123 ++++++++++++
 tb/tb_soc_mem_rmw.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/soc_mem_rmw_if.sv
// CPU data-port and BRAM-side signals of the sub-word RMW adapter.
// slave is the adapter's view; master is the CPU + memory side.
interface soc_mem_rmw_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [31:0]           i_dwrite;
  logic [1:0]            i_size;
  logic                  i_sext;
  logic                  i_rw;
  logic                  i_stb;
  logic [31:0]           o_dread;
  logic                  o_ack;
  logic                  o_err;
  logic                  o_busy;
  logic [ADDR_WIDTH-1:0] o_maddr;
  logic [31:0]           o_mdwrite;
  logic                  o_mrw;
  logic                  o_mstb;
  logic                  i_mack;
  logic [31:0]           i_mdread;

  modport slave (
    input  i_addr, i_dwrite, i_size, i_sext, i_rw, i_stb, i_mack, i_mdread,
    output o_dread, o_ack, o_err, o_busy, o_maddr, o_mdwrite, o_mrw, o_mstb
  );

  modport master (
    output i_addr, i_dwrite, i_size, i_sext, i_rw, i_stb, i_mack, i_mdread,
    input  o_dread, o_ack, o_err, o_busy, o_maddr, o_mdwrite, o_mrw, o_mstb
  );
endinterface

// File: rtl/soc_mem_rmw.sv
// Byte/half/word load-store adapter in front of soc_bram_ctl; sub-word stores
// become read-merge-write on the big-endian 32-bit dword at the request address.
module soc_mem_rmw #(
  parameter int ADDR_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input logic           i_clk,
  input logic           i_reset,
  soc_mem_rmw_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  size;
    logic        sext;
    logic        rw;
  } req_t;

  state_t      state;
  req_t        req;
  logic [23:0] rbuf;
  logic [3:0]  cnt;
  logic        timeout;

  assign timeout = !bus.i_mack && (cnt == 4'(ACK_TIMEOUT - 1));

  // Big-endian: the addressed byte/half sits at the top of the dword.
  function automatic logic [31:0] load_fmt(input logic [31:0] d, input logic [1:0] size,
                                           input logic sext);
    case (size)
      2'b00:   load_fmt = {{24{sext & d[31]}}, d[31:24]};
      2'b01:   load_fmt = {{16{sext & d[31]}}, d[31:16]};
      default: load_fmt = d;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      req           <= '0;
      rbuf          <= '0;
      cnt           <= '0;
      bus.o_ack     <= 1'b0;
      bus.o_err     <= 1'b0;
      bus.o_busy    <= 1'b0;
      bus.o_mstb    <= 1'b0;
      bus.o_mrw     <= 1'b0;
      bus.o_maddr   <= '0;
      bus.o_mdwrite <= '0;
      bus.o_dread   <= '0;
    end else begin
      bus.o_ack  <= 1'b0;
      bus.o_err  <= 1'b0;
      bus.o_mstb <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_stb) begin
            req         <= '{data: bus.i_dwrite[15:0], size: bus.i_size,
                             sext: bus.i_sext, rw: bus.i_rw};
            bus.o_busy  <= 1'b1;
            bus.o_maddr <= bus.i_addr;
            bus.o_mstb  <= 1'b1;
            cnt         <= '0;
            if (bus.i_rw && bus.i_size[1]) begin
              state         <= WR;
              bus.o_mrw     <= 1'b1;
              bus.o_mdwrite <= bus.i_dwrite;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (bus.i_mack) begin
            rbuf <= bus.i_mdread[23:0];
            if (req.rw) begin
              state <= MERGE;
            end else begin
              state       <= DONE;
              bus.o_ack   <= 1'b1;
              bus.o_dread <= load_fmt(bus.i_mdread, req.size, req.sext);
            end
          end else if (timeout) begin
            state       <= DONE;
            bus.o_ack   <= 1'b1;
            bus.o_err   <= 1'b1;
            bus.o_dread <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        // o_mdwrite doubles as the merged write buffer for the WR phase.
        MERGE: begin
          state         <= WR;
          cnt           <= '0;
          bus.o_mstb    <= 1'b1;
          bus.o_mrw     <= 1'b1;
          bus.o_mdwrite <= req.size[0] ? {req.data[15:0], rbuf[15:0]}
                                       : {req.data[7:0], rbuf[23:0]};
        end
        WR: begin
          if (bus.i_mack || timeout) begin
            state       <= DONE;
            bus.o_mrw   <= 1'b0;
            bus.o_ack   <= 1'b1;
            bus.o_err   <= !bus.i_mack;
            bus.o_dread <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_mem_rmw.sv
// Directed bench for soc_mem_rmw against a byte-array BRAM model that acks one
// cycle after a strobe and writes on every edge o_mrw is high.
module tb_soc_mem_rmw;

  localparam int AW = 8;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  soc_mem_rmw_if #(.ADDR_WIDTH(AW)) bus();

  soc_mem_rmw #(.ADDR_WIDTH(AW), .ACK_TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  logic [7:0] mem [256];
  bit         noack = 1'b0;

  always @(posedge clk) begin
    bus.i_mack <= 1'b0;
    if (bus.o_mrw)
      for (int k = 0; k < 4; k++) mem[8'(bus.o_maddr + 8'(k))] <= bus.o_mdwrite[31-8*k -: 8];
    if (bus.o_mstb && !noack) begin
      bus.i_mack   <= 1'b1;
      bus.i_mdread <= {mem[bus.o_maddr], mem[8'(bus.o_maddr + 8'd1)],
                       mem[8'(bus.o_maddr + 8'd2)], mem[8'(bus.o_maddr + 8'd3)]};
    end
  end

  int   ack_cnt = 0;
  int   mrw_rises = 0;
  logic mrw_q = 1'b0;
  always @(negedge clk) begin
    if (bus.o_ack) ack_cnt++;
    if (bus.o_mrw && !mrw_q) mrw_rises++;
    mrw_q = bus.o_mrw;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts on a negedge, returns on the negedge of the cycle after o_ack.
  // lat = posedges from raising i_stb to o_ack seen (o_ack in cycle lat+1).
  task automatic xact(input logic rw, input logic [1:0] size, input logic sext,
                      input logic [7:0] addr, input logic [31:0] d, input bit probe,
                      output logic [31:0] rd, output int lat, output logic err,
                      output int rises, output logic busy1);
    int r0;
    r0 = mrw_rises;
    bus.i_rw = rw; bus.i_size = size; bus.i_sext = sext;
    bus.i_addr = addr; bus.i_dwrite = d; bus.i_stb = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); bus.i_stb = 1'b0; busy1 = bus.o_busy;
    while (!bus.o_ack && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    rd = bus.o_dread; err = bus.o_err;
    chk("ack_seen", {31'd0, bus.o_ack}, 32'd1);
    if (probe) begin
      // Word store raised in the o_ack cycle; must be dropped.
      bus.i_rw = 1'b1; bus.i_size = 2'b10; bus.i_dwrite = 32'hDEADBEEF; bus.i_stb = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    bus.i_stb = 1'b0;
    #1 rises = mrw_rises - r0;
  endtask

  logic [31:0] rd;
  int          lat, rises, a0, r0;
  logic        err, busy1;

  initial begin
    bus.i_addr = '0; bus.i_dwrite = '0; bus.i_size = '0; bus.i_sext = 1'b0;
    bus.i_rw = 1'b0; bus.i_stb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",  {31'd0, bus.o_ack},  32'd0);
    chk("rst_err",  {31'd0, bus.o_err},  32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_mstb", {31'd0, bus.o_mstb}, 32'd0);
    chk("rst_mrw",  {31'd0, bus.o_mrw},  32'd0);
    chk("rst_maddr", {24'd0, bus.o_maddr}, 32'd0);
    chk("rst_mdwrite", bus.o_mdwrite, 32'd0);
    chk("rst_dread", bus.o_dread, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store then word load.
    xact(1, 2'b10, 0, 8'h10, 32'h12345678, 0, rd, lat, err, rises, busy1);
    chk("wst_lat", 32'(lat), 32'd3);
    chk("wst_rises", 32'(rises), 32'd1);
    chk("wst_err", {31'd0, err}, 32'd0);
    chk("wst_busy", {31'd0, busy1}, 32'd1);
    chk("wst_busy_after", {31'd0, bus.o_busy}, 32'd0);
    xact(0, 2'b10, 0, 8'h10, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("wld_data", rd, 32'h12345678);
    chk("wld_lat", 32'(lat), 32'd3);

    // Byte store RMW at an unaligned address.
    xact(1, 2'b00, 0, 8'h11, 32'h000000AB, 0, rd, lat, err, rises, busy1);
    chk("bst_lat", 32'(lat), 32'd6);
    chk("bst_rises", 32'(rises), 32'd1);
    xact(0, 2'b10, 0, 8'h10, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("bst_readback", rd, 32'h12AB5678);

    // Half store straddling the 0x10/0x14 dword boundary.
    xact(1, 2'b10, 0, 8'h10, 32'h12345678, 0, rd, lat, err, rises, busy1);
    xact(1, 2'b10, 0, 8'h14, 32'h9ABCDEF0, 0, rd, lat, err, rises, busy1);
    xact(1, 2'b01, 0, 8'h13, 32'h0000BEEF, 0, rd, lat, err, rises, busy1);
    chk("hst_lat", 32'(lat), 32'd6);
    chk("hst_rises", 32'(rises), 32'd1);
    xact(0, 2'b10, 0, 8'h10, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("hst_rd10", rd, 32'h123456BE);
    xact(0, 2'b10, 0, 8'h14, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("hst_rd14", rd, 32'hEFBCDEF0);

    // Sign/zero extension.
    xact(1, 2'b10, 0, 8'h20, 32'h00112233, 0, rd, lat, err, rises, busy1);
    xact(1, 2'b00, 0, 8'h20, 32'hFFFFFF80, 0, rd, lat, err, rises, busy1);
    xact(0, 2'b00, 1, 8'h20, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("lb_sext", rd, 32'hFFFFFF80);
    xact(0, 2'b00, 0, 8'h20, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("lb_zext", rd, 32'h00000080);
    xact(0, 2'b01, 1, 8'h20, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("lh_sext", rd, 32'hFFFF8011);
    xact(0, 2'b01, 0, 8'h21, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("lh_zext", rd, 32'h00001122);
    xact(0, 2'b11, 1, 8'h20, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("lw_size3", rd, 32'h80112233);

    // Request raised in the o_ack cycle is dropped.
    xact(0, 2'b10, 0, 8'h10, 32'h0, 1, rd, lat, err, rises, busy1);
    a0 = ack_cnt;
    repeat (6) @(negedge clk);
    chk("drop_no_ack", 32'(ack_cnt - a0), 32'd0);
    xact(0, 2'b10, 0, 8'h10, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("drop_mem", rd, 32'h123456BE);

    // Memory never acks: timeout abort.
    noack = 1'b1;
    xact(0, 2'b10, 0, 8'h10, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("to_ld_lat", 32'(lat), 32'(TO + 1));
    chk("to_ld_err", {31'd0, err}, 32'd1);
    chk("to_ld_data", rd, 32'h0);
    xact(1, 2'b00, 0, 8'h10, 32'h00000055, 0, rd, lat, err, rises, busy1);
    chk("to_st_err", {31'd0, err}, 32'd1);
    chk("to_st_rises", 32'(rises), 32'd0);
    noack = 1'b0;
    @(negedge clk);
    xact(0, 2'b10, 0, 8'h10, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("to_mem", rd, 32'h123456BE);
    chk("to_ok_err", {31'd0, err}, 32'd0);

    // Reset while a byte store sits in MERGE.
    a0 = ack_cnt; r0 = mrw_rises;
    bus.i_rw = 1'b1; bus.i_size = 2'b00; bus.i_addr = 8'h10;
    bus.i_dwrite = 32'h00000077; bus.i_stb = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.i_stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_busy", {31'd0, bus.o_busy}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mrst_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("mrst_no_mrw", 32'(mrw_rises - r0), 32'd0);
    xact(0, 2'b10, 0, 8'h10, 32'h0, 0, rd, lat, err, rises, busy1);
    chk("mrst_mem", rd, 32'h123456BE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
